// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// 3-sample majority vote per bit, false-start rejection and parity/framing/break flags.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx_serial,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int         MID        = CLKS_PER_BIT / 2;
    localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] SAMPLE_A  = 16'(MID - 1);
    localparam logic [15:0] SAMPLE_B  = 16'(MID);
    localparam logic [15:0] SAMPLE_C  = 16'(MID + 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic        ODD_TARGET = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [15:0]          cnt;
    logic [3:0]           bit_idx;
    logic                 samp_a;
    logic                 samp_b;
    logic                 vote;
    logic                 vote_now;
    logic                 wrap;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 parity_bad;
    logic                 stop_err;
    logic                 any_one;
    logic                 wait_high;

    // Two-flop synchroniser; the line idles high so reset loads ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_serial;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        vote     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        vote_now = (cnt == SAMPLE_C);
        wrap     = (cnt == CNT_LAST);
    end

    always_comb begin
        parity_bad = 1'b0;
        if (PARITY != 0) begin
            parity_bad = ((^shift_reg) ^ par_bit) != ODD_TARGET;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            cnt          <= 16'd0;
            bit_idx      <= 4'd0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            stop_err     <= 1'b0;
            any_one      <= 1'b0;
            wait_high    <= 1'b0;
            o_rx_dv      <= 1'b0;
            o_rx_byte    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_rx_dv <= 1'b0;
            if (state == S_IDLE) begin
                cnt <= 16'd0;
                // After a break the line must return high before a new start counts.
                if (wait_high) begin
                    if (rx_s) begin
                        wait_high <= 1'b0;
                    end
                end else if (!rx_s) begin
                    state    <= S_START;
                    o_busy   <= 1'b1;
                    bit_idx  <= 4'd0;
                    stop_err <= 1'b0;
                    any_one  <= 1'b0;
                end
            end else begin
                cnt <= wrap ? 16'd0 : cnt + 16'd1;
                if (cnt == SAMPLE_A) begin
                    samp_a <= rx_s;
                end
                if (cnt == SAMPLE_B) begin
                    samp_b <= rx_s;
                end
                case (state)
                    S_START: begin
                        if (vote_now && vote) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end else if (wrap) begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (vote_now) begin
                            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                            any_one   <= any_one | vote;
                        end
                        if (wrap) begin
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= 4'd0;
                                state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (vote_now) begin
                            par_bit <= vote;
                            any_one <= any_one | vote;
                        end
                        if (wrap) begin
                            state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (wrap && bit_idx != LAST_STOP) begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                        if (vote_now) begin
                            if (bit_idx != LAST_STOP) begin
                                stop_err <= stop_err | ~vote;
                                any_one  <= any_one | vote;
                            end else begin
                                // Last stop vote closes the frame mid-bit so the next start is seen early.
                                state        <= S_IDLE;
                                o_busy       <= 1'b0;
                                o_rx_dv      <= 1'b1;
                                o_rx_byte    <= shift_reg;
                                o_parity_err <= parity_bad;
                                o_frame_err  <= stop_err | ~vote;
                                o_break      <= ~(any_one | vote);
                                wait_high    <= ~(any_one | vote);
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Adds configurable data width, parity, stop-bit count, 3-sample majority vote per bit, false-start rejection, and parity/framing/break flags.
- Sits between the async serial pin and the byte-stream consumer (FIFO or register bank).
- Emits one registered valid pulse per received frame.

Parameters:
CLKS_PER_BIT, 8, clocks per bit period; legal values 4..65535; MID = CLKS_PER_BIT/2 (integer division).
DATA_BITS, 8, data bits per frame; legal values 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_rx_serial  in  1  asynchronous serial line; idle high
o_rx_dv  out  1  one-cycle pulse: frame complete, o_rx_byte and flags valid
o_rx_byte  out  DATA_BITS  received data, LSB first on the line
o_parity_err  out  1  parity mismatch for the frame flagged by o_rx_dv; 0 when PARITY=0
o_frame_err  out  1  at least one stop bit voted 0
o_break  out  1  every data bit, the parity bit (if present) and all stop bits voted 0
o_busy  out  1  high in any state other than IDLE

Behaviour:
Reset
- On any i_clk edge with i_rst=1: state=IDLE, counters=0, synchroniser FFs=1.
- Outputs reset to: o_rx_dv=0, o_rx_byte=0, all flags=0, o_busy=0.
- Reset mid-frame aborts the frame; no o_rx_dv is produced for it.

Input synchroniser
- i_rx_serial passes through 2 FFs; the FSM sees only the synchronised line, rx_s.
- T0 = first edge at which FF1 samples 0.

Bit timer and majority vote
- Bit counter cnt runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Each bit samples rx_s at cnt = MID-1, MID and MID+1.
- The bit value is the majority of the three samples, resolved at cnt = MID+1.

FSM states: IDLE, START, DATA, PARITY, STOP
- IDLE -> START when rx_s=0 (edge T0+2); cnt=0.
- START: if the vote is 1, treat as a false start: return to IDLE at the vote cycle; no dv, no flags.
- START: if the vote is 0, go to DATA at the cnt wrap.
- DATA: shift voted bits into the shift register LSB first; after DATA_BITS bits go to PARITY (PARITY != 0) or STOP.
- PARITY: record the voted bit; compare to XOR of the data bits.
  - Odd parity: the total count of ones, including the parity bit, must be odd.
  - Even parity: the total count must be even.
- STOP: vote each stop bit.
  - Not the last stop bit: advance to the next stop bit at the wrap.
  - Last stop bit: at its vote cycle, go to IDLE immediately (early resync) and register the outputs.

Output timing
- o_rx_dv=1 for exactly one cycle.
- Frame length N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- o_rx_dv is high in the cycle after edge T0 + 2 + (N-1)*CLKS_PER_BIT + MID + 2.
- Example: default parameters, N=10 -> o_rx_dv high after edge T0+80.
- o_rx_byte and flags update in the same edge as o_rx_dv and hold until the next frame's dv.

Flags
- o_frame_err=1 if any stop bit voted 0.
- o_break=1 implies o_frame_err=1.
- After o_break, IDLE waits for rx_s=1 before accepting a new start, so a held-low line produces a single break frame only.

Back-to-back frames
- A start edge arriving any time after the last stop vote, including the very next cycle, is accepted.

Glitches
- A single-cycle glitch at any sample point is outvoted and does not change the received bit.

Test Plan:
1. Defaults, send 0x59 (line bits 1,0,0,1,1,0,1,0), stop=1 -> o_rx_dv single pulse after edge T0+80; o_rx_byte=0x59; all flags 0; o_busy high from T0+2 until the dv edge.
2. PARITY=2, DATA_BITS=7: send 0x41 with parity bit 0 -> byte 0x41, o_parity_err=0. Resend 0x41 with parity bit 1 -> dv asserted, o_parity_err=1.
3. STOP_BITS=2: send 0xA5 with second stop bit 0 -> byte 0xA5, o_frame_err=1, o_break=0.
4. Line held low for 15 bit periods, then released -> exactly one dv with byte 0x00, o_break=1, o_frame_err=1. No further dv until a new start edge after the line returns high.
5. Low pulse of 2 cycles (false start), then 1-cycle high glitch at MID of data bit 3 while sending 0x00 -> no dv from the false start; next frame decodes byte 0x00 with flags 0.
6. Assert i_rst during data bit 4 of a 0xFF frame, release, then send 0x3C -> no dv for the aborted frame; outputs 0 during reset; 0x3C received correctly.
